// File: rtl/pipe_ctrl_pkg.sv
// Shared types and default widths for the pipeline sequencer.
package pipe_ctrl_pkg;

  localparam int PCTL_REG_IDX_W = 5;
  localparam int PCTL_CNT_W     = 32;

  typedef enum logic [0:0] {
    ST_RUN,
    ST_MEM_WAIT
  } pctl_state_e;

  typedef enum logic [1:0] {
    FWD_REG = 2'b00,
    FWD_MEM = 2'b01,
    FWD_WB  = 2'b10
  } fwd_sel_e;

endpackage

// File: rtl/pipe_ctrl_if.sv
// Stage-status inputs and pipeline-control outputs between the core datapath and pipe_ctrl.
interface pipe_ctrl_if
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_IDX_W = PCTL_REG_IDX_W
);
  logic                 id_valid;
  logic [REG_IDX_W-1:0] id_rs1_ind;
  logic [REG_IDX_W-1:0] id_rs2_ind;
  logic                 id_rs1_used;
  logic                 id_rs2_used;
  logic                 ex_valid;
  logic [REG_IDX_W-1:0] ex_rs1_ind;
  logic [REG_IDX_W-1:0] ex_rs2_ind;
  logic [REG_IDX_W-1:0] ex_rd_ind;
  logic                 ex_wr_en;
  logic                 ex_is_load;
  logic                 mem_valid;
  logic [REG_IDX_W-1:0] mem_rd_ind;
  logic                 mem_wr_en;
  logic                 mem_jmp_take;
  logic                 mem_req;
  logic                 mem_ready;
  logic [REG_IDX_W-1:0] wb_rd_ind;
  logic                 wb_wr_en;

  logic     if_en;
  logic     id_en;
  logic     ex_en;
  logic     mem_en;
  logic     id_flush;
  logic     ex_flush;
  logic     mem_flush;
  logic     pc_redirect;
  fwd_sel_e fwd_a_sel;
  fwd_sel_e fwd_b_sel;

  modport master (
    output id_valid, id_rs1_ind, id_rs2_ind, id_rs1_used, id_rs2_used,
           ex_valid, ex_rs1_ind, ex_rs2_ind, ex_rd_ind, ex_wr_en, ex_is_load,
           mem_valid, mem_rd_ind, mem_wr_en, mem_jmp_take, mem_req, mem_ready,
           wb_rd_ind, wb_wr_en,
    input  if_en, id_en, ex_en, mem_en, id_flush, ex_flush, mem_flush,
           pc_redirect, fwd_a_sel, fwd_b_sel
  );

  modport slave (
    input  id_valid, id_rs1_ind, id_rs2_ind, id_rs1_used, id_rs2_used,
           ex_valid, ex_rs1_ind, ex_rs2_ind, ex_rd_ind, ex_wr_en, ex_is_load,
           mem_valid, mem_rd_ind, mem_wr_en, mem_jmp_take, mem_req, mem_ready,
           wb_rd_ind, wb_wr_en,
    output if_en, id_en, ex_en, mem_en, id_flush, ex_flush, mem_flush,
           pc_redirect, fwd_a_sel, fwd_b_sel
  );

endinterface

// File: rtl/pipe_ctrl_fwd_unit.sv
// Operand forwarding select for one execute-stage source; the younger MEM result wins over WB.
module fwd_unit
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_IDX_W = PCTL_REG_IDX_W
) (
  input  logic [REG_IDX_W-1:0] ex_rs_ind,
  input  logic                 mem_valid,
  input  logic                 mem_wr_en,
  input  logic [REG_IDX_W-1:0] mem_rd_ind,
  input  logic                 wb_wr_en,
  input  logic [REG_IDX_W-1:0] wb_rd_ind,
  output fwd_sel_e             fwd_sel
);

  always_comb begin
    fwd_sel = FWD_REG;
    if (ex_rs_ind != '0) begin
      if (mem_valid && mem_wr_en && (mem_rd_ind == ex_rs_ind)) begin
        fwd_sel = FWD_MEM;
      end else if (wb_wr_en && (wb_rd_ind == ex_rs_ind)) begin
        fwd_sel = FWD_WB;
      end
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: register enables/flushes, PC redirect, forwarding selects, perf counters.
//  state       | meaning
//  ST_RUN      | pipeline advancing (normal, redirect or load-use bubble)
//  ST_MEM_WAIT | data memory has not yet accepted/returned; whole pipe frozen
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_IDX_W = PCTL_REG_IDX_W,
  parameter int CNT_W     = PCTL_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  pipe_ctrl_if.slave       bus,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events
);

  pctl_state_e      state_q, state_d;
  logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
  logic [CNT_W-1:0] flush_events_q, flush_events_d;

  logic     mem_stall, redirect, load_use, rs1_hit, rs2_hit;
  fwd_sel_e fwd_a, fwd_b;

  fwd_unit #(.REG_IDX_W(REG_IDX_W)) u_fwd_a (
    .ex_rs_ind  (bus.ex_rs1_ind),
    .mem_valid  (bus.mem_valid),
    .mem_wr_en  (bus.mem_wr_en),
    .mem_rd_ind (bus.mem_rd_ind),
    .wb_wr_en   (bus.wb_wr_en),
    .wb_rd_ind  (bus.wb_rd_ind),
    .fwd_sel    (fwd_a)
  );

  fwd_unit #(.REG_IDX_W(REG_IDX_W)) u_fwd_b (
    .ex_rs_ind  (bus.ex_rs2_ind),
    .mem_valid  (bus.mem_valid),
    .mem_wr_en  (bus.mem_wr_en),
    .mem_rd_ind (bus.mem_rd_ind),
    .wb_wr_en   (bus.wb_wr_en),
    .wb_rd_ind  (bus.wb_rd_ind),
    .fwd_sel    (fwd_b)
  );

  // The cycle mem_ready rises the access completes, so the pipe advances that same cycle.
  assign mem_stall = ((state_q == ST_MEM_WAIT) || bus.mem_req) && !bus.mem_ready;
  assign redirect  = bus.mem_valid && bus.mem_jmp_take;
  assign rs1_hit   = bus.id_rs1_used && (bus.id_rs1_ind == bus.ex_rd_ind);
  assign rs2_hit   = bus.id_rs2_used && (bus.id_rs2_ind == bus.ex_rd_ind);
  assign load_use  = bus.ex_valid && bus.ex_is_load && bus.ex_wr_en &&
                     (bus.ex_rd_ind != '0) && bus.id_valid && (rs1_hit || rs2_hit);

  always_comb begin
    state_d         = state_q;
    stall_cycles_d  = stall_cycles_q;
    flush_events_d  = flush_events_q;
    bus.if_en       = 1'b1;
    bus.id_en       = 1'b1;
    bus.ex_en       = 1'b1;
    bus.mem_en      = 1'b1;
    bus.id_flush    = 1'b0;
    bus.ex_flush    = 1'b0;
    bus.mem_flush   = 1'b0;
    bus.pc_redirect = 1'b0;
    bus.fwd_a_sel   = fwd_a;
    bus.fwd_b_sel   = fwd_b;

    if (!rst_n) begin
      state_d         = ST_RUN;
      stall_cycles_d  = '0;
      flush_events_d  = '0;
      bus.if_en       = 1'b0;
      bus.id_en       = 1'b0;
      bus.ex_en       = 1'b0;
      bus.mem_en      = 1'b0;
      bus.id_flush    = 1'b1;
      bus.ex_flush    = 1'b1;
      bus.mem_flush   = 1'b1;
      bus.fwd_a_sel   = FWD_REG;
      bus.fwd_b_sel   = FWD_REG;
    end else if (mem_stall) begin
      state_d        = ST_MEM_WAIT;
      stall_cycles_d = stall_cycles_q + CNT_W'(1);
      bus.if_en      = 1'b0;
      bus.id_en      = 1'b0;
      bus.ex_en      = 1'b0;
      bus.mem_en     = 1'b0;
    end else begin
      state_d = ST_RUN;
      if (redirect) begin
        flush_events_d  = flush_events_q + CNT_W'(1);
        bus.pc_redirect = 1'b1;
        bus.id_flush    = 1'b1;
        bus.ex_flush    = 1'b1;
      end else if (load_use) begin
        stall_cycles_d = stall_cycles_q + CNT_W'(1);
        bus.if_en      = 1'b0;
        bus.id_en      = 1'b0;
        bus.ex_flush   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= ST_RUN;
      stall_cycles_q <= '0;
      flush_events_q <= '0;
    end else begin
      state_q        <= state_d;
      stall_cycles_q <= stall_cycles_d;
      flush_events_q <= flush_events_d;
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign flush_events = flush_events_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed-vector bench for pipe_ctrl; control word = {if,id,ex,mem en, id,ex,mem flush, redirect}.
module tb_pipe_ctrl;
  import pipe_ctrl_pkg::*;

  localparam logic [7:0] C_NORMAL   = 8'b1111_0000;
  localparam logic [7:0] C_RESET    = 8'b0000_1110;
  localparam logic [7:0] C_STALL    = 8'b0000_0000;
  localparam logic [7:0] C_LOADUSE  = 8'b0011_0100;
  localparam logic [7:0] C_REDIRECT = 8'b1111_1101;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] stall_cycles, flush_events;
  int          vec_cnt = 0;
  int          miss_cnt = 0;

  pipe_ctrl_if bus ();

  pipe_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .stall_cycles (stall_cycles),
    .flush_events (flush_events)
  );

  always #5 clk = ~clk;

  wire [7:0] ctl = {bus.if_en, bus.id_en, bus.ex_en, bus.mem_en,
                    bus.id_flush, bus.ex_flush, bus.mem_flush, bus.pc_redirect};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_idle();
    bus.id_valid = 0; bus.id_rs1_ind = 0; bus.id_rs2_ind = 0;
    bus.id_rs1_used = 0; bus.id_rs2_used = 0;
    bus.ex_valid = 0; bus.ex_rs1_ind = 0; bus.ex_rs2_ind = 0; bus.ex_rd_ind = 0;
    bus.ex_wr_en = 0; bus.ex_is_load = 0;
    bus.mem_valid = 0; bus.mem_rd_ind = 0; bus.mem_wr_en = 0; bus.mem_jmp_take = 0;
    bus.mem_req = 0; bus.mem_ready = 0;
    bus.wb_rd_ind = 0; bus.wb_wr_en = 0;
  endtask

  task automatic set_load_use();
    bus.ex_valid = 1; bus.ex_is_load = 1; bus.ex_wr_en = 1; bus.ex_rd_ind = 5;
    bus.id_valid = 1; bus.id_rs1_ind = 5; bus.id_rs1_used = 1;
  endtask

  task automatic test_reset();
    set_idle();
    rst_n = 0;
    bus.mem_valid = 1; bus.mem_wr_en = 1; bus.mem_rd_ind = 3;
    bus.ex_rs1_ind = 3; bus.ex_rs2_ind = 3;
    settle();
    vec_cnt++;
    if (ctl !== C_RESET) begin
      miss_cnt++; $display("FAIL reset_ctl got=%b exp=%b", ctl, C_RESET);
    end
    vec_cnt++;
    if ({bus.fwd_a_sel, bus.fwd_b_sel} !== 4'b0000) begin
      miss_cnt++; $display("FAIL reset_fwd got=%b exp=0000", {bus.fwd_a_sel, bus.fwd_b_sel});
    end
    tick();
    tick();
    vec_cnt++;
    if ({stall_cycles, flush_events} !== 64'd0) begin
      miss_cnt++; $display("FAIL reset_cnt got=%0d/%0d exp=0/0", stall_cycles, flush_events);
    end
    rst_n = 1;
    set_idle();
    settle();
    vec_cnt++;
    if (ctl !== C_NORMAL) begin
      miss_cnt++; $display("FAIL reset_release_ctl got=%b exp=%b", ctl, C_NORMAL);
    end
  endtask

  task automatic test_load_use();
    set_idle();
    set_load_use();
    settle();
    vec_cnt++;
    if (ctl !== C_LOADUSE) begin
      miss_cnt++; $display("FAIL lu_ctl got=%b exp=%b", ctl, C_LOADUSE);
    end
    tick();
    vec_cnt++;
    if (stall_cycles !== 32'd1) begin
      miss_cnt++; $display("FAIL lu_stall_cnt got=%0d exp=1", stall_cycles);
    end
    set_idle();
    bus.mem_valid = 1; bus.mem_wr_en = 1; bus.mem_rd_ind = 5;
    bus.ex_valid = 1; bus.ex_rs1_ind = 5;
    settle();
    vec_cnt++;
    if (ctl !== C_NORMAL || bus.fwd_a_sel !== FWD_MEM) begin
      miss_cnt++; $display("FAIL lu_next got ctl=%b fwd_a=%b exp ctl=%b fwd_a=01",
                           ctl, bus.fwd_a_sel, C_NORMAL);
    end
    tick();
    vec_cnt++;
    if (stall_cycles !== 32'd1) begin
      miss_cnt++; $display("FAIL lu_single_bubble got=%0d exp=1", stall_cycles);
    end
  endtask

  task automatic test_no_hazard();
    set_idle();
    set_load_use();
    bus.ex_rd_ind = 0; bus.id_rs1_ind = 0;
    settle();
    vec_cnt++;
    if (ctl !== C_NORMAL) begin
      miss_cnt++; $display("FAIL nohaz_x0 got=%b exp=%b", ctl, C_NORMAL);
    end
    set_load_use();
    bus.id_rs1_used = 0;
    settle();
    vec_cnt++;
    if (ctl !== C_NORMAL) begin
      miss_cnt++; $display("FAIL nohaz_unused got=%b exp=%b", ctl, C_NORMAL);
    end
    bus.ex_is_load = 0; bus.id_rs1_used = 1;
    settle();
    vec_cnt++;
    if (ctl !== C_NORMAL) begin
      miss_cnt++; $display("FAIL nohaz_not_load got=%b exp=%b", ctl, C_NORMAL);
    end
    set_load_use();
    bus.id_rs1_ind = 9; bus.id_rs2_ind = 5; bus.id_rs2_used = 1;
    settle();
    vec_cnt++;
    if (ctl !== C_LOADUSE) begin
      miss_cnt++; $display("FAIL lu_rs2 got=%b exp=%b", ctl, C_LOADUSE);
    end
    tick();
    vec_cnt++;
    if (stall_cycles !== 32'd2) begin
      miss_cnt++; $display("FAIL lu_rs2_cnt got=%0d exp=2", stall_cycles);
    end
  endtask

  task automatic test_mem_stall();
    set_idle();
    bus.mem_req = 1; bus.mem_ready = 0;
    bus.mem_valid = 1; bus.mem_jmp_take = 1;
    for (int i = 0; i < 3; i++) begin
      settle();
      vec_cnt++;
      if (ctl !== C_STALL) begin
        miss_cnt++; $display("FAIL mstall_ctl cyc=%0d got=%b exp=%b", i, ctl, C_STALL);
      end
      tick();
    end
    vec_cnt++;
    if (stall_cycles !== 32'd5 || flush_events !== 32'd0) begin
      miss_cnt++; $display("FAIL mstall_cnt got=%0d/%0d exp=5/0", stall_cycles, flush_events);
    end
    bus.mem_ready = 1;
    settle();
    vec_cnt++;
    if (ctl !== C_REDIRECT) begin
      miss_cnt++; $display("FAIL mstall_release got=%b exp=%b", ctl, C_REDIRECT);
    end
    tick();
    set_idle();
    settle();
    vec_cnt++;
    if (ctl !== C_NORMAL || stall_cycles !== 32'd5 || flush_events !== 32'd1) begin
      miss_cnt++; $display("FAIL mstall_after got=%b %0d/%0d exp=%b 5/1",
                           ctl, stall_cycles, flush_events, C_NORMAL);
    end
  endtask

  task automatic test_redirect();
    set_idle();
    set_load_use();
    bus.mem_valid = 1; bus.mem_jmp_take = 1;
    settle();
    vec_cnt++;
    if (ctl !== C_REDIRECT) begin
      miss_cnt++; $display("FAIL redir_ctl got=%b exp=%b", ctl, C_REDIRECT);
    end
    tick();
    vec_cnt++;
    if (flush_events !== 32'd2 || stall_cycles !== 32'd5) begin
      miss_cnt++; $display("FAIL redir_cnt got=%0d/%0d exp=2/5", flush_events, stall_cycles);
    end
    bus.mem_valid = 0;
    settle();
    vec_cnt++;
    if (ctl !== C_LOADUSE) begin
      miss_cnt++; $display("FAIL redir_needs_valid got=%b exp=%b", ctl, C_LOADUSE);
    end
    set_idle();
  endtask

  task automatic test_forwarding();
    set_idle();
    bus.mem_valid = 1; bus.mem_wr_en = 1; bus.mem_rd_ind = 7;
    bus.wb_wr_en = 1; bus.wb_rd_ind = 7;
    bus.ex_rs1_ind = 4; bus.ex_rs2_ind = 7;
    settle();
    vec_cnt++;
    if (bus.fwd_b_sel !== FWD_MEM || bus.fwd_a_sel !== FWD_REG) begin
      miss_cnt++; $display("FAIL fwd_mem got a=%b b=%b exp a=00 b=01", bus.fwd_a_sel, bus.fwd_b_sel);
    end
    bus.mem_wr_en = 0;
    settle();
    vec_cnt++;
    if (bus.fwd_b_sel !== FWD_WB) begin
      miss_cnt++; $display("FAIL fwd_wb got=%b exp=10", bus.fwd_b_sel);
    end
    bus.mem_wr_en = 1; bus.mem_valid = 0; bus.ex_rs1_ind = 7;
    settle();
    vec_cnt++;
    if (bus.fwd_a_sel !== FWD_WB) begin
      miss_cnt++; $display("FAIL fwd_mem_invalid got=%b exp=10", bus.fwd_a_sel);
    end
    bus.mem_valid = 1; bus.mem_rd_ind = 0; bus.wb_rd_ind = 0;
    bus.ex_rs1_ind = 0; bus.ex_rs2_ind = 0;
    settle();
    vec_cnt++;
    if ({bus.fwd_a_sel, bus.fwd_b_sel} !== 4'b0000) begin
      miss_cnt++; $display("FAIL fwd_x0 got=%b exp=0000", {bus.fwd_a_sel, bus.fwd_b_sel});
    end
    bus.mem_rd_ind = 3; bus.wb_rd_ind = 6; bus.wb_wr_en = 0;
    bus.ex_rs1_ind = 6; bus.ex_rs2_ind = 3;
    settle();
    vec_cnt++;
    if ({bus.fwd_a_sel, bus.fwd_b_sel} !== 4'b0001) begin
      miss_cnt++; $display("FAIL fwd_mix got=%b exp=0001", {bus.fwd_a_sel, bus.fwd_b_sel});
    end
    set_idle();
  endtask

  task automatic test_reset_mid_stall();
    set_idle();
    bus.mem_req = 1; bus.mem_ready = 0;
    tick();
    rst_n = 0;
    settle();
    vec_cnt++;
    if (ctl !== C_RESET) begin
      miss_cnt++; $display("FAIL rst_stall_ctl got=%b exp=%b", ctl, C_RESET);
    end
    tick();
    vec_cnt++;
    if ({stall_cycles, flush_events} !== 64'd0) begin
      miss_cnt++; $display("FAIL rst_stall_cnt got=%0d/%0d exp=0/0", stall_cycles, flush_events);
    end
    rst_n = 1;
    bus.mem_req = 0; bus.mem_ready = 0;
    settle();
    vec_cnt++;
    if (ctl !== C_NORMAL) begin
      miss_cnt++; $display("FAIL rst_stall_run got=%b exp=%b", ctl, C_NORMAL);
    end
    tick();
    vec_cnt++;
    if (stall_cycles !== 32'd0) begin
      miss_cnt++; $display("FAIL rst_stall_after got=%0d exp=0", stall_cycles);
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_no_hazard();
    test_mem_stall();
    test_redirect();
    test_forwarding();
    test_reset_mid_stall();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
